spi_i2c_cmd_ctrl: RTL

//   Consumes the byte stream from spi_slave (rx_data/rx_valid/busy) and turns each CS frame

---
 rtl/spi_i2c_cmd_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_i2c_cmd_ctrl.sv
// ============================================================================
// spi_i2c_cmd_ctrl
//
// Purpose
//   Turns each SPI chip-select frame received from spi_slave into one I2C
//   master command. Frame byte0 = {addr[6:0], rw}. For writes, the following
//   bytes are payload buffered in a write FIFO and streamed to the I2C master.
//   For reads, byte1 is the read length N; bytes returned by the I2C master
//   are buffered in a read FIFO and handed back to spi_slave as tx_data, one
//   byte per later frame.
//
// Configuration macro
//   STATUS_BYTE_EN : when defined, tx_data shows the status byte while the
//                    read FIFO is empty, so an SPI master can poll with dummy
//                    frames. When undefined, tx_data is 8'h00 while empty.
//
// Parameters
//   FIFO_DEPTH : entries per FIFO (power of 2, 2..16); also max transfer length
//   CNT_W      : width of length fields; must be able to hold FIFO_DEPTH
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_data/rx_valid/spi_busy  byte stream and CS-active flag from spi_slave
//   tx_data/tx_valid/tx_ready  read-back byte to spi_slave, pop strobe
//   cmd_valid/cmd_ready        command handshake to the I2C master
//   cmd_addr/cmd_rw/cmd_len    command fields, stable while cmd_valid
//   wr_data/wr_valid/wr_ready  write payload stream to the I2C master
//   rd_data/rd_valid           read bytes from the I2C master
//   cmd_done/cmd_nack          transaction finished / target NACKed
//   status                     {ctrl_busy, nack, ovf, frame_err, 0, rd_count[2:0]}
// ============================================================================
module spi_i2c_cmd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             spi_busy,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [6:0]       cmd_addr,
    output logic             cmd_rw,
    output logic [CNT_W-1:0] cmd_len,
    output logic [7:0]       wr_data,
    output logic             wr_valid,
    input  logic             wr_ready,
    input  logic [7:0]       rd_data,
    input  logic             rd_valid,
    input  logic             cmd_done,
    input  logic             cmd_nack,
    output logic [7:0]       status
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FC_W  = CNT_W + 1;
    localparam logic [FC_W-1:0]  DEPTH_FC  = FC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_LEN = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_RLEN  = 3'd2,
        S_ISSUE = 3'd3,
        S_EXEC  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // command fields and sticky flags
    logic             r_busy_q;
    logic [6:0]       r_addr;
    logic             r_rw;
    logic [CNT_W-1:0] r_len;
    logic             r_len_got;
    logic             r_nack;
    logic             r_ovf;
    logic             r_ferr;

    // write FIFO
    logic [7:0]       r_wr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_wptr;
    logic [PTR_W-1:0] r_wr_rptr;
    logic [FC_W-1:0]  r_wr_cnt;

    // read FIFO
    logic [7:0]       r_rd_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_wptr;
    logic [PTR_W-1:0] r_rd_rptr;
    logic [FC_W-1:0]  r_rd_cnt;

    // FSM strobes
    logic w_frame_end;
    logic w_hdr_acc;
    logic w_wr_push;
    logic w_len_acc;
    logic w_len_missing;
    logic w_empty_wr;
    logic w_rx_drop;
    logic w_done;
    logic w_rd_push;

    // FIFO control
    logic w_wr_nempty;
    logic w_wr_push_ok;
    logic w_wr_pop;
    logic w_wr_flush;
    logic w_rd_nempty;
    logic w_rd_push_ok;
    logic w_rd_pop;
    logic w_rd_flush;
    logic w_len_bad;

    // End of frame: CS was active last cycle and is now released.
    assign w_frame_end = r_busy_q & ~spi_busy;

    assign w_wr_nempty  = (r_wr_cnt != '0);
    assign w_rd_nempty  = (r_rd_cnt != '0);
    assign w_wr_push_ok = w_wr_push & (r_wr_cnt != DEPTH_FC);
    assign w_wr_pop     = wr_valid & wr_ready;
    assign w_wr_flush   = w_empty_wr | w_done;
    // A full read FIFO can still take a byte if an entry leaves in the same cycle.
    assign w_rd_push_ok = w_rd_push & ((r_rd_cnt != DEPTH_FC) | w_rd_pop);
    assign w_rd_pop     = tx_ready & w_rd_nempty;
    assign w_rd_flush   = w_hdr_acc & rx_data[0];
    assign w_len_bad    = (rx_data == 8'd0) || (rx_data > 8'(FIFO_DEPTH));

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_hdr_acc     = 1'b0;
        w_wr_push     = 1'b0;
        w_len_acc     = 1'b0;
        w_len_missing = 1'b0;
        w_empty_wr    = 1'b0;
        w_rx_drop     = 1'b0;
        w_done        = 1'b0;
        w_rd_push     = 1'b0;
        cmd_valid     = 1'b0;
        wr_valid      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A header arriving as the frame closes is a header-only frame: ignore it.
                if (rx_valid && !w_frame_end) begin
                    w_hdr_acc   = 1'b1;
                    w_state_nxt = rx_data[0] ? S_RLEN : S_WDATA;
                end
            end
            S_WDATA: begin
                w_wr_push = rx_valid;
                if (w_frame_end) begin
                    // No payload stored and none arriving this cycle.
                    if ((r_wr_cnt == '0) && !rx_valid) begin
                        w_empty_wr  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_RLEN: begin
                w_len_acc = rx_valid && !r_len_got;
                if (w_frame_end) begin
                    w_len_missing = !r_len_got && !w_len_acc;
                    w_state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cmd_valid = 1'b1;
                w_rx_drop = rx_valid;
                if (cmd_ready) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_rx_drop = rx_valid;
                wr_valid  = !r_rw && w_wr_nempty;
                w_rd_push = rd_valid;
                if (cmd_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Command fields and sticky flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_q  <= 1'b0;
            r_addr    <= '0;
            r_rw      <= 1'b0;
            r_len     <= '0;
            r_len_got <= 1'b0;
            r_nack    <= 1'b0;
            r_ovf     <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_busy_q <= spi_busy;
            if (w_hdr_acc) begin
                r_addr    <= rx_data[7:1];
                r_rw      <= rx_data[0];
                r_len     <= '0;
                r_len_got <= 1'b0;
                r_nack    <= 1'b0;
                r_ovf     <= 1'b0;
                r_ferr    <= 1'b0;
            end
            // Write length tracks bytes actually stored, so dropped bytes are not counted.
            if (w_wr_push_ok) begin
                r_len <= r_len + CNT_W'(1);
            end
            if (w_len_acc) begin
                r_len_got <= 1'b1;
                if (w_len_bad) begin
                    r_ferr <= 1'b1;
                    r_len  <= DEPTH_LEN;
                end else begin
                    r_len  <= rx_data[CNT_W-1:0];
                end
            end
            // Read frame closed before any length byte: treat like N==0.
            if (w_len_missing) begin
                r_ferr <= 1'b1;
                r_len  <= DEPTH_LEN;
            end
            if (w_empty_wr) begin
                r_ferr <= 1'b1;
            end
            if ((w_wr_push && !w_wr_push_ok) || w_rx_drop || (w_rd_push && !w_rd_push_ok)) begin
                r_ovf <= 1'b1;
            end
            if (w_done) begin
                r_nack <= cmd_nack;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_wptr <= '0;
            r_wr_rptr <= '0;
            r_wr_cnt  <= '0;
        end else if (w_wr_flush) begin
            r_wr_wptr <= '0;
            r_wr_rptr <= '0;
            r_wr_cnt  <= '0;
        end else begin
            if (w_wr_push_ok) begin
                r_wr_wptr <= r_wr_wptr + PTR_W'(1);
            end
            if (w_wr_pop) begin
                r_wr_rptr <= r_wr_rptr + PTR_W'(1);
            end
            case ({w_wr_push_ok, w_wr_pop})
                2'b10:   r_wr_cnt <= r_wr_cnt + FC_W'(1);
                2'b01:   r_wr_cnt <= r_wr_cnt - FC_W'(1);
                default: r_wr_cnt <= r_wr_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_push_ok) begin
            r_wr_mem[r_wr_wptr] <= rx_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_wptr <= '0;
            r_rd_rptr <= '0;
            r_rd_cnt  <= '0;
        end else if (w_rd_flush) begin
            r_rd_wptr <= '0;
            r_rd_rptr <= '0;
            r_rd_cnt  <= '0;
        end else begin
            if (w_rd_push_ok) begin
                r_rd_wptr <= r_rd_wptr + PTR_W'(1);
            end
            if (w_rd_pop) begin
                r_rd_rptr <= r_rd_rptr + PTR_W'(1);
            end
            case ({w_rd_push_ok, w_rd_pop})
                2'b10:   r_rd_cnt <= r_rd_cnt + FC_W'(1);
                2'b01:   r_rd_cnt <= r_rd_cnt - FC_W'(1);
                default: r_rd_cnt <= r_rd_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_push_ok) begin
            r_rd_mem[r_rd_wptr] <= rd_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_addr = r_addr;
    assign cmd_rw   = r_rw;
    assign cmd_len  = r_len;
    assign tx_valid = w_rd_nempty;
    assign status   = {(r_state != S_IDLE), r_nack, r_ovf, r_ferr, 1'b0, r_rd_cnt[2:0]};
    // Heads are gated so empty FIFOs never expose uninitialised storage.
    assign wr_data  = w_wr_nempty ? r_wr_mem[r_wr_rptr] : 8'h00;
`ifdef STATUS_BYTE_EN
    assign tx_data  = w_rd_nempty ? r_rd_mem[r_rd_rptr] : status;
`else
    assign tx_data  = w_rd_nempty ? r_rd_mem[r_rd_rptr] : 8'h00;
`endif

endmodule
